prog_sequence_detector: RTL and testbench
=========================================

Name: prog_sequence_detector

Overview:
- Parametrised serial bit-pattern detector. It succeeds the fixed 4-bit "1011" Moore detector.
- Pattern, pattern length and overlap mode are runtime-programmable. Input bits are qualified by a valid strobe.
- Keeps a saturating match counter.
- Sits on a serial input path; z drives downstream framing/alignment logic.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits. Legal range 2..32.
- CNT_W, 8: width of match_count.
- DEF_PATTERN, 8'b0000_1011: pattern loaded at reset, right-aligned, MAX_LEN bits.
- DEF_LEN, 4: length loaded at reset.
- DEF_OVERLAP, 1: overlap mode loaded at reset.
- LEN_W, $clog2(MAX_LEN+1): derived; width of the length field.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- cfg_load, in, 1: latch cfg_pattern, cfg_len and cfg_overlap this cycle.
- cfg_pattern, in, MAX_LEN: pattern, right-aligned. Bit [len-1] is the first bit received; bit [0] is the last.
- cfg_len, in, LEN_W: pattern length.
- cfg_overlap, in, 1: 1 = overlapping matches allowed; 0 = non-overlapping.
- x_valid, in, 1: x is sampled only when high.
- x, in, 1: serial data bit.
- z, out, 1: registered match pulse.
- match_count, out, CNT_W: saturating count of matches.
- cfg_err, out, 1: active configuration is illegal.

Behaviour:
- Reset (async, rst=1):
  - hist=0, fill=0, z=0, match_count=0, cfg_err=0.
  - pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP.
  - Out of reset the block detects "1011" overlapping.
- State:
  - hist[MAX_LEN-1:0] is a shift register of accepted bits.
  - fill (0..MAX_LEN) counts bits accepted since the last reset, load or non-overlap match. It saturates at MAX_LEN.
- Accept (x_valid=1, cfg_load=0, cfg_err=0):
  - hist_n = {hist[MAX_LEN-2:0], x}.
  - fill_n = min(fill+1, MAX_LEN).
  - match = (fill_n >= len) and (hist_n[len-1:0] == pattern[len-1:0]). Only the low len bits are compared.
- Output timing:
  - z=1 on the clock edge that accepts the completing bit, i.e. z is high in the cycle after x is presented (Moore-equivalent).
  - z is high for exactly one cycle per match.
  - z=0 in every cycle following a clock edge that produced no match, including x_valid=0 cycles.
- Overlap modes:
  - overlap=1: fill keeps counting after a match, so a match suffix can start the next match.
  - overlap=0: on a match, fill is set to 0 and the next match needs len fresh bits. hist still shifts.
- x_valid=0: hist, fill and match_count hold; x is ignored.
- match_count increments on each match and saturates at 2^CNT_W-1. It never wraps.
- cfg_load=1:
  - Latch the new config; clear hist, fill, z and match_count.
  - cfg_load has priority over x_valid in the same cycle; that sample is dropped.
- cfg_err is set by a load with cfg_len < 2 or cfg_len > MAX_LEN.
  - While cfg_err=1: no bit is accepted, z=0 and match_count holds at 0.
  - A subsequent legal load clears cfg_err.
- Reset mid-stream discards partial progress; the first match after reset needs DEF_LEN fresh bits.
- Arithmetic: fill and len compare unsigned at LEN_W bits. Pattern bits above len-1 are don't-care.

Test Plan:
1. Reset defaults. Stream x=1,0,1,1,0,1,1 (x_valid=1 every cycle) → z high the cycle after bit 4 and after bit 7, low otherwise; match_count=2.
2. Load len=3, pattern=101, overlap=0. Stream 1,0,1,0,1 → one z pulse after bit 3; match_count=1. Reload with overlap=1 and repeat → pulses after bits 3 and 5; match_count=2.
3. Defaults, stream 1,0 then x_valid=0 for 3 cycles with x=1, then 1,1 → no z during the gap; single z after the final 1; match_count=1.
4. Load cfg_len=0 → cfg_err=1. Stream 1,0,1,1 → z stays 0, count 0. Load len=4, pattern=1011 → cfg_err=0 and detection resumes.
5. MAX_LEN=8, CNT_W=2. Load len=8, pattern=8'hA5, overlap=1. Stream A5 repeated 5 times → 5 z pulses; match_count saturates at 3.
6. Defaults, stream 1,0,1, assert rst for 1 cycle, then 1 → no z. cfg_load asserted together with x_valid → sample dropped and counters cleared.

Source files
------------

// File: rtl/prog_sequence_detector.sv
// Programmable serial bit-pattern detector.
// Pattern, length and overlap mode can be reloaded at runtime. Input bits are
// qualified by x_valid. z is a registered one-cycle match pulse, and
// match_count is a saturating tally of matches since the last reset or load.
module prog_sequence_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0000_1011,
  parameter int                 DEF_LEN     = 4,
  parameter bit                 DEF_OVERLAP = 1'b1,
  parameter int                 LEN_W       = $clog2(MAX_LEN+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               x_valid,
  input  logic               x,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  // Only MAX_LEN-1 past bits are stored. The newest bit of the comparison
  // window comes straight from x, so the oldest bit of a full-length window
  // is the top stored bit.
  logic [MAX_LEN-2:0] histQ, histD;
  logic [LEN_W-1:0]   fillQ, fillD;
  logic               zQ, zD;
  logic [CNT_W-1:0]   countQ, countD;
  logic               errQ, errD;
  logic [MAX_LEN-1:0] patQ, patD;
  logic [LEN_W-1:0]   lenQ, lenD;
  logic               ovlQ, ovlD;

  logic [MAX_LEN-1:0] histN;
  logic [LEN_W-1:0]   fillInc;
  logic               accept;
  logic               patMatch;
  logic               match;
  logic               cfgIllegal;

  // Compute the candidate window and decide whether the accepted bit completes a match.
  always_comb begin
    accept     = x_valid && !cfg_load && !errQ;
    histN      = {histQ, x};
    fillInc    = (fillQ == LEN_W'(MAX_LEN)) ? fillQ : fillQ + LEN_W'(1);
    cfgIllegal = (cfg_len < LEN_W'(2)) || (cfg_len > LEN_W'(MAX_LEN));
    patMatch   = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < lenQ) && (histN[i] != patQ[i])) begin
        patMatch = 1'b0;
      end
    end
    match = accept && (fillInc >= lenQ) && patMatch;
  end

  // Next-state selection: a configuration load wins over a data sample in the same cycle.
  always_comb begin
    histD  = histQ;
    fillD  = fillQ;
    zD     = 1'b0;
    countD = countQ;
    errD   = errQ;
    patD   = patQ;
    lenD   = lenQ;
    ovlD   = ovlQ;
    if (cfg_load) begin
      patD   = cfg_pattern;
      lenD   = cfg_len;
      ovlD   = cfg_overlap;
      errD   = cfgIllegal;
      histD  = '0;
      fillD  = '0;
      countD = '0;
    end else if (accept) begin
      histD = histN[MAX_LEN-2:0];
      zD    = match;
      if (match && !ovlQ) begin
        fillD = '0;
      end else begin
        fillD = fillInc;
      end
      if (match && (countQ != {CNT_W{1'b1}})) begin
        countD = countQ + CNT_W'(1);
      end
    end
  end

  // State registers; reset restores the default "1011" overlapping configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      histQ  <= '0;
      fillQ  <= '0;
      zQ     <= 1'b0;
      countQ <= '0;
      errQ   <= 1'b0;
      patQ   <= DEF_PATTERN;
      lenQ   <= LEN_W'(DEF_LEN);
      ovlQ   <= DEF_OVERLAP;
    end else begin
      histQ  <= histD;
      fillQ  <= fillD;
      zQ     <= zD;
      countQ <= countD;
      errQ   <= errD;
      patQ   <= patD;
      lenQ   <= lenD;
      ovlQ   <= ovlD;
    end
  end

  assign z           = zQ;
  assign match_count = countQ;
  assign cfg_err     = errQ;

endmodule

// File: tb/tb_prog_sequence_detector.sv
// Self-checking bench for prog_sequence_detector.
// Two instances share all inputs: one with the default 8-bit counter and one
// with a 2-bit counter so that saturation is reachable quickly.
module tb_prog_sequence_detector;

  logic       clk;
  logic       rst;
  logic       cfgLoad;
  logic [7:0] cfgPattern;
  logic [3:0] cfgLen;
  logic       cfgOverlap;
  logic       xValid;
  logic       xBit;
  logic       zA, zB;
  logic [7:0] countA;
  logic [1:0] countB;
  logic       errA, errB;

  int compared;
  int mismatched;

  // Reference model: the bits accepted since the last reset, load or
  // non-overlapping match, newest at the back, plus the active configuration.
  bit   q[$];
  logic [7:0] mPat;
  int   mLen;
  bit   mOvl;
  bit   mErr;
  int   mCntA;
  int   mCntB;
  bit   expZ;

  prog_sequence_detector dutA (
    .clk(clk), .rst(rst), .cfg_load(cfgLoad), .cfg_pattern(cfgPattern),
    .cfg_len(cfgLen), .cfg_overlap(cfgOverlap), .x_valid(xValid), .x(xBit),
    .z(zA), .match_count(countA), .cfg_err(errA)
  );

  prog_sequence_detector #(.CNT_W(2)) dutB (
    .clk(clk), .rst(rst), .cfg_load(cfgLoad), .cfg_pattern(cfgPattern),
    .cfg_len(cfgLen), .cfg_overlap(cfgOverlap), .x_valid(xValid), .x(xBit),
    .z(zB), .match_count(countB), .cfg_err(errB)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    q.delete();
    mPat  = 8'b0000_1011;
    mLen  = 4;
    mOvl  = 1'b1;
    mErr  = 1'b0;
    mCntA = 0;
    mCntB = 0;
    expZ  = 1'b0;
  endtask

  // True when the last mLen accepted bits spell the pattern, first bit = pattern[mLen-1].
  function automatic bit modelMatch();
    if (q.size() < mLen) return 1'b0;
    for (int k = 0; k < mLen; k++) begin
      if (q[q.size() - 1 - k] != mPat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic compareAll(input string tag);
    checkOutput({tag, "_zA"}, {31'd0, zA}, {31'd0, expZ});
    checkOutput({tag, "_zB"}, {31'd0, zB}, {31'd0, expZ});
    checkOutput({tag, "_cntA"}, {24'd0, countA}, mCntA);
    checkOutput({tag, "_cntB"}, {30'd0, countB}, mCntB);
    checkOutput({tag, "_errA"}, {31'd0, errA}, {31'd0, mErr});
    checkOutput({tag, "_errB"}, {31'd0, errB}, {31'd0, mErr});
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic applyStimulus(input logic load, input logic [7:0] pat, input logic [3:0] len,
                               input logic ovl, input logic xv, input logic xx);
    @(negedge clk);
    cfgLoad    = load;
    cfgPattern = pat;
    cfgLen     = len;
    cfgOverlap = ovl;
    xValid     = xv;
    xBit       = xx;
    @(posedge clk);
    expZ = 1'b0;
    if (load) begin
      mPat  = pat;
      mLen  = int'(len);
      mOvl  = ovl;
      mErr  = (len < 2) || (len > 8);
      q.delete();
      mCntA = 0;
      mCntB = 0;
    end else if (xv && !mErr) begin
      q.push_back(xx);
      if (q.size() > 8) void'(q.pop_front());
      if (modelMatch()) begin
        expZ = 1'b1;
        if (mCntA < 255) mCntA++;
        if (mCntB < 3) mCntB++;
        if (!mOvl) q.delete();
      end
    end
    #1;
    compareAll("step");
  endtask

  task automatic sendBit(input logic b);
    applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b);
  endtask

  task automatic idleGap(input logic b);
    applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, b);
  endtask

  task automatic loadCfg(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    applyStimulus(1'b1, pat, len, ovl, 1'b0, 1'b0);
  endtask

  task automatic sendBits(input logic [7:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(bits[i]);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst     = 1'b1;
    cfgLoad = 1'b0;
    xValid  = 1'b0;
    #1;
    checkOutput("rstAsync_z", {31'd0, zA}, 32'd0);
    checkOutput("rstAsync_cnt", {24'd0, countA}, 32'd0);
    @(posedge clk);
    #1;
    modelReset();
    compareAll("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [6:0] zSeen;

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    cfgLoad    = 1'b0;
    cfgPattern = 8'h00;
    cfgLen     = 4'd0;
    cfgOverlap = 1'b0;
    xValid     = 1'b0;
    xBit       = 1'b0;
    modelReset();
    doReset();

    // Defaults detect "1011" with overlap.
    zSeen = '0;
    begin
      logic [6:0] t1;
      t1 = 7'b1011011;
      for (int i = 6; i >= 0; i--) begin
        sendBit(t1[i]);
        zSeen = {zSeen[5:0], zA};
      end
    end
    checkOutput("t1_zPattern", {25'd0, zSeen}, 32'b0001001);
    checkOutput("t1_count", {24'd0, countA}, 32'd2);

    // len=3 "101": non-overlap then overlap.
    loadCfg(8'b101, 4'd3, 1'b0);
    sendBits(8'b10101, 5);
    checkOutput("t2_noOvlCount", {24'd0, countA}, 32'd1);
    loadCfg(8'b101, 4'd3, 1'b1);
    sendBits(8'b10101, 5);
    checkOutput("t2_ovlCount", {24'd0, countA}, 32'd2);

    // Gap with x_valid low.
    doReset();
    sendBits(8'b10, 2);
    for (int i = 0; i < 3; i++) begin
      idleGap(1'b1);
      checkOutput("t3_gapZ", {31'd0, zA}, 32'd0);
    end
    sendBit(1'b1);
    checkOutput("t3_zEarly", {31'd0, zA}, 32'd0);
    sendBit(1'b1);
    checkOutput("t3_zFinal", {31'd0, zA}, 32'd1);
    checkOutput("t3_count", {24'd0, countA}, 32'd1);

    // Illegal length and recovery.
    loadCfg(8'b1011, 4'd0, 1'b1);
    checkOutput("t4_errSet", {31'd0, errA}, 32'd1);
    sendBits(8'b1011, 4);
    checkOutput("t4_errZ", {31'd0, zA}, 32'd0);
    checkOutput("t4_errCount", {24'd0, countA}, 32'd0);
    loadCfg(8'b1011, 4'd9, 1'b1);
    checkOutput("t4_errLen9", {31'd0, errA}, 32'd1);
    loadCfg(8'b1011, 4'd4, 1'b1);
    checkOutput("t4_errClear", {31'd0, errA}, 32'd0);
    sendBits(8'b1011, 4);
    checkOutput("t4_resumeZ", {31'd0, zA}, 32'd1);

    // Full-length pattern and counter saturation.
    loadCfg(8'hA5, 4'd8, 1'b1);
    for (int r = 0; r < 5; r++) sendBits(8'hA5, 8);
    checkOutput("t5_countA", {24'd0, countA}, 32'd5);
    checkOutput("t5_countSat", {30'd0, countB}, 32'd3);

    // Reset mid-stream, then load colliding with a valid sample.
    doReset();
    sendBits(8'b101, 3);
    doReset();
    sendBit(1'b1);
    checkOutput("t6_afterRstZ", {31'd0, zA}, 32'd0);
    sendBits(8'b101, 3);
    applyStimulus(1'b1, 8'b1011, 4'd4, 1'b1, 1'b1, 1'b1);
    checkOutput("t6_loadDropZ", {31'd0, zA}, 32'd0);
    checkOutput("t6_loadDropCnt", {24'd0, countA}, 32'd0);
    sendBits(8'b011, 3);
    checkOutput("t6_noStaleMatch", {31'd0, zA}, 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 1) begin
        doReset();
      end else if (r < 5) begin
        logic [3:0] l;
        l = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(2, 4)) : 4'($urandom_range(0, 10));
        loadCfg(8'($urandom), l, 1'($urandom));
      end else begin
        applyStimulus(1'b0, 8'h00, 4'd0, 1'b0, $urandom_range(0, 3) != 0, 1'($urandom));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
